// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// states and a small op-classification helper.
package mdu_iter_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // True for the ops that go through the multi-cycle datapath.
  function automatic logic is_iter_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers. One shared
// 2*WIDTH shift register and one WIDTH+1 adder/subtractor serve both ops.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: start is accepted only while busy is low (IDLE); a launched
  // iterative op keeps busy high until the cycle done pulses, and any start
  // seen while busy is dropped, never queued.

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  mdu_op_e            op;
  logic               signed_op;
  logic               div_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     addsub_in;
  logic [WIDTH:0]     addsub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op        = mdu_op_e'(oper);
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign div_op    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Division compares the left-shifted partial remainder against the divisor;
  // multiplication adds the multiplicand into the upper half before shifting.
  assign addsub_in = div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign addsub    = div_q ? (addsub_in - {1'b0, m_q}) : (addsub_in + {1'b0, m_q});

  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    m_d        = m_q;
    a_raw_d    = a_raw_q;
    div_d      = div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      MDU_IDLE: begin
        if (start && !cancel) begin
          if (is_iter_op(op)) begin
            div_d     = div_op;
            acc_d     = {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
            m_d       = div_op ? b_mag : a_mag;
            a_raw_d   = a;
            neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = signed_op && a[WIDTH-1];
            dz_d      = div_op && (b == '0);
            cnt_d     = '0;
            state_d   = MDU_RUN;
          end else if (op == MDU_MTHI) begin
            hi_d   = a;
            done_d = 1'b1;
          end else if (op == MDU_MTLO) begin
            lo_d   = a;
            done_d = 1'b1;
          end
        end
      end

      MDU_RUN: begin
        if (cancel) begin
          state_d = MDU_IDLE;
        end else begin
          if (div_q) begin
            if (!addsub[WIDTH]) begin
              acc_d = {addsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {(acc_q[0] ? addsub : {1'b0, acc_q[2*WIDTH-1:WIDTH]}),
                     acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MDU_FIX;
          end
        end
      end

      MDU_FIX: begin
        state_d = MDU_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            hi_d       = a_raw_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end

      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MDU_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      a_raw_q    <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      m_q        <= m_d;
      a_raw_q    <= a_raw_d;
      div_q      <= div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != MDU_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed MUL/DIV results, latency, MTHI/MTLO,
// cancel, ignored starts and asynchronous reset.
module tb_mdu_iter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   oper;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests;
  int n_fail;

  mdu_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .oper     (oper),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one iterative op, then watch every edge until done (bounded).
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output logic busy_ok, output logic busy_at_done,
                       output logic dz_at_done);
    @(negedge clk);
    start = 1'b1; oper = op; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_ok = 1'b1; busy_at_done = 1'b1; dz_at_done = 1'b0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k; busy_at_done = busy; dz_at_done = div_zero;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input logic exp_dz);
    int   lat;
    logic bok, bdone, dz;
    do_op(op, av, bv, lat, bok, bdone, dz);
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " busy during op"}, 64'(bok), 64'd1);
    check({tag, " busy at done"}, 64'(bdone), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(dz), 64'(exp_dz));
  endtask

  // Counts done pulses over n edges.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    n_tests = 0; n_fail = 0;
    start = 1'b0; oper = 3'd0; a = '0; b = '0; cancel = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_check("mult -3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_check("mult min*min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_check("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("divu 7/2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_check("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_check("divu 5/0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_check("div -5/0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_check("div 100/-7", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);

    // MTHI / MTLO seed
    @(negedge clk);
    start = 1'b1; oper = 3'd4; a = 32'h11;
    @(posedge clk); #1;
    check("mthi done", 64'(done), 64'd1);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi hi", 64'(hi), 64'h11);
    @(negedge clk);
    oper = 3'd5; a = 32'h22;
    @(posedge clk); #1;
    check("mtlo done", 64'(done), 64'd1);
    check("mtlo lo", 64'(lo), 64'h22);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("mtlo done drops", 64'(done), 64'd0);

    // cancel together with start in IDLE: nothing written
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; oper = 3'd4; a = 32'hDEAD;
    @(posedge clk); #1;
    check("cancel+mthi done", 64'(done), 64'd0);
    check("cancel+mthi hi", 64'(hi), 64'h11);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;

    // undefined op code ignored
    @(negedge clk);
    start = 1'b1; oper = 3'd7; a = 32'h5; b = 32'h6;
    @(posedge clk); #1;
    check("undef busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    count_done(5, cnt);
    check("undef no done", 64'(cnt), 64'd0);

    // MULT cancelled mid-run
    @(negedge clk);
    start = 1'b1; oper = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("cancel pre busy", 64'(busy), 64'd1);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel busy low", 64'(busy), 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    count_done(LAT + 5, cnt);
    check("cancel no done", 64'(cnt), 64'd0);
    check("cancel hi kept", 64'(hi), 64'h11);
    check("cancel lo kept", 64'(lo), 64'h22);

    // second start while busy is ignored
    @(negedge clk);
    start = 1'b1; oper = 3'd1; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; oper = 3'd4; a = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    count_done(LAT + 10, cnt);
    check("busy start one done", 64'(cnt), 64'd1);
    check("busy start hi", 64'(hi), 64'd0);
    check("busy start lo", 64'(lo), 64'd12);

    // asynchronous reset mid DIV
    @(negedge clk);
    start = 1'b1; oper = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(LAT + 5, cnt);
    check("async rst no done", 64'(cnt), 64'd0);
    run_check("post rst multu", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
